// File: rtl/rom_arb.sv
// rom_arb: two-master OCP arbiter sharing one single-port slave, one transaction in flight.
// Define ROM_ARB_WRITE_ERR_EN to answer writes locally with an ERR response instead of forwarding.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif
`ifndef OCP_CMD_IDLE
`define OCP_CMD_IDLE 3'd0
`define OCP_CMD_WRITE 3'd1
`define OCP_CMD_READ 3'd2
`endif
`ifndef OCP_RESP_NULL
`define OCP_RESP_NULL 2'd0
`define OCP_RESP_DVA 2'd1
`define OCP_RESP_FAIL 2'd2
`define OCP_RESP_ERR 2'd3
`endif

module rom_arb #(
  parameter bit FAIR = 1'b1
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [`ADDR_WIDTH-1:0] i_m0_MAddr,
  input  logic [2:0]             i_m0_MCmd,
  input  logic [`DATA_WIDTH-1:0] i_m0_MData,
  input  logic [`BEN_WIDTH-1:0]  i_m0_MByteEn,
  output logic                   o_m0_SCmdAccept,
  output logic [`DATA_WIDTH-1:0] o_m0_SData,
  output logic [1:0]             o_m0_SResp,
  input  logic [`ADDR_WIDTH-1:0] i_m1_MAddr,
  input  logic [2:0]             i_m1_MCmd,
  input  logic [`DATA_WIDTH-1:0] i_m1_MData,
  input  logic [`BEN_WIDTH-1:0]  i_m1_MByteEn,
  output logic                   o_m1_SCmdAccept,
  output logic [`DATA_WIDTH-1:0] o_m1_SData,
  output logic [1:0]             o_m1_SResp,
  output logic [`ADDR_WIDTH-1:0] o_s_MAddr,
  output logic [2:0]             o_s_MCmd,
  output logic [`DATA_WIDTH-1:0] o_s_MData,
  output logic [`BEN_WIDTH-1:0]  o_s_MByteEn,
  input  logic                   i_s_SCmdAccept,
  input  logic [`DATA_WIDTH-1:0] i_s_SData,
  input  logic [1:0]             i_s_SResp
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, prio_q, prio_d;
  logic req0, req1, gnt, acc, wr_err;
  logic [2:0] sel_cmd;
  logic [1:0] resp;
  logic [`DATA_WIDTH-1:0] data;

  assign req0 = i_m0_MCmd != `OCP_CMD_IDLE;
  assign req1 = i_m1_MCmd != `OCP_CMD_IDLE;
  assign gnt = (req0 && req1) ? (FAIR ? prio_q : 1'b0) : req1;
  assign sel_cmd = gnt ? i_m1_MCmd : i_m0_MCmd;

`ifdef ROM_ARB_WRITE_ERR_EN
  logic err_pend_q, err_pend_d;
  assign wr_err = sel_cmd == `OCP_CMD_WRITE;
  // The error response always completes in the single WAIT cycle that follows.
  assign err_pend_d = (state_q == IDLE) && acc && wr_err;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) err_pend_q <= 1'b0;
    else err_pend_q <= err_pend_d;
`else
  assign wr_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d = prio_q;
    o_s_MCmd = `OCP_CMD_IDLE;
    o_s_MAddr = '0;
    o_s_MData = '0;
    o_s_MByteEn = '0;
    acc = 1'b0;
    resp = `OCP_RESP_NULL;
    data = '0;
    if (state_q == IDLE) begin
      if ((req0 || req1) && !wr_err) begin
        o_s_MCmd = sel_cmd;
        o_s_MAddr = gnt ? i_m1_MAddr : i_m0_MAddr;
        o_s_MData = gnt ? i_m1_MData : i_m0_MData;
        o_s_MByteEn = gnt ? i_m1_MByteEn : i_m0_MByteEn;
      end
      acc = (req0 || req1) && (wr_err || i_s_SCmdAccept);
      if (acc) begin
        state_d = WAIT;
        owner_d = gnt;
        prio_d = FAIR ? ~gnt : prio_q;
      end
    end else begin
      resp = i_s_SResp;
      data = i_s_SData;
`ifdef ROM_ARB_WRITE_ERR_EN
      resp = err_pend_q ? `OCP_RESP_ERR : resp;
      data = err_pend_q ? '1 : data;
`endif
      state_d = (resp != `OCP_RESP_NULL) ? IDLE : WAIT;
    end
  end

  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q <= prio_d;
    end

  assign o_m0_SCmdAccept = acc && !gnt;
  assign o_m1_SCmdAccept = acc && gnt;
  assign o_m0_SResp = owner_q ? `OCP_RESP_NULL : resp;
  assign o_m1_SResp = owner_q ? resp : `OCP_RESP_NULL;
  assign o_m0_SData = owner_q ? '0 : data;
  assign o_m1_SData = owner_q ? data : '0;
endmodule

// File: tb/tb_rom_arb.sv
// tb_rom_arb: table-driven check of rom_arb plus reset, fixed-priority and contention sequences.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif
`ifndef OCP_CMD_IDLE
`define OCP_CMD_IDLE 3'd0
`define OCP_CMD_WRITE 3'd1
`define OCP_CMD_READ 3'd2
`endif
`ifndef OCP_RESP_NULL
`define OCP_RESP_NULL 2'd0
`define OCP_RESP_DVA 2'd1
`define OCP_RESP_FAIL 2'd2
`define OCP_RESP_ERR 2'd3
`endif

module tb_rom_arb;
  localparam logic [2:0] I = 3'd0, WR = 3'd1, RD = 3'd2;
  localparam logic [1:0] N = 2'd0, D = 2'd1, E = 2'd3;
  logic clk = 1'b0, nrst = 1'b0;
  always #5 clk = ~clk;
  logic [`ADDR_WIDTH-1:0] m0_addr, m1_addr, rr_s_addr, fp_s_addr;
  logic [2:0] m0_cmd, m1_cmd, rr_s_cmd, fp_s_cmd;
  logic [`DATA_WIDTH-1:0] m0_data, m1_data, s_data, rr_s_data, fp_s_data;
  logic [`DATA_WIDTH-1:0] rr_d0, rr_d1, fp_d0, fp_d1;
  logic [`BEN_WIDTH-1:0] m0_ben, m1_ben, rr_s_ben, fp_s_ben;
  logic s_acc, rr_acc0, rr_acc1, fp_acc0, fp_acc1;
  logic [1:0] s_resp, rr_r0, rr_r1, fp_r0, fp_r1;
  int total = 0, bad = 0;

  rom_arb #(.FAIR(1'b1)) u_rr (
    .clk(clk), .nrst(nrst),
    .i_m0_MAddr(m0_addr), .i_m0_MCmd(m0_cmd), .i_m0_MData(m0_data), .i_m0_MByteEn(m0_ben),
    .o_m0_SCmdAccept(rr_acc0), .o_m0_SData(rr_d0), .o_m0_SResp(rr_r0),
    .i_m1_MAddr(m1_addr), .i_m1_MCmd(m1_cmd), .i_m1_MData(m1_data), .i_m1_MByteEn(m1_ben),
    .o_m1_SCmdAccept(rr_acc1), .o_m1_SData(rr_d1), .o_m1_SResp(rr_r1),
    .o_s_MAddr(rr_s_addr), .o_s_MCmd(rr_s_cmd), .o_s_MData(rr_s_data), .o_s_MByteEn(rr_s_ben),
    .i_s_SCmdAccept(s_acc), .i_s_SData(s_data), .i_s_SResp(s_resp));

  rom_arb #(.FAIR(1'b0)) u_fp (
    .clk(clk), .nrst(nrst),
    .i_m0_MAddr(m0_addr), .i_m0_MCmd(m0_cmd), .i_m0_MData(m0_data), .i_m0_MByteEn(m0_ben),
    .o_m0_SCmdAccept(fp_acc0), .o_m0_SData(fp_d0), .o_m0_SResp(fp_r0),
    .i_m1_MAddr(m1_addr), .i_m1_MCmd(m1_cmd), .i_m1_MData(m1_data), .i_m1_MByteEn(m1_ben),
    .o_m1_SCmdAccept(fp_acc1), .o_m1_SData(fp_d1), .o_m1_SResp(fp_r1),
    .o_s_MAddr(fp_s_addr), .o_s_MCmd(fp_s_cmd), .o_s_MData(fp_s_data), .o_s_MByteEn(fp_s_ben),
    .i_s_SCmdAccept(s_acc), .i_s_SData(s_data), .i_s_SResp(s_resp));

  typedef struct {
    logic [2:0] c0; logic [31:0] a0; logic [2:0] c1; logic [31:0] a1; logic [31:0] d1;
    logic sa; logic [1:0] sr; logic [31:0] sd;
    logic [2:0] e_cmd; logic [31:0] e_addr; logic [31:0] e_mdata;
    logic e_acc0, e_acc1; logic [1:0] e_r0, e_r1; logic [31:0] e_d0, e_d1;
  } vec_t;
  vec_t tv[21];

  function automatic vec_t mk(logic [2:0] c0, logic [31:0] a0, logic [2:0] c1, logic [31:0] a1,
      logic [31:0] d1, logic sa, logic [1:0] sr, logic [31:0] sd, logic [2:0] e_cmd,
      logic [31:0] e_addr, logic [31:0] e_mdata, logic e_acc0, logic e_acc1,
      logic [1:0] e_r0, logic [1:0] e_r1, logic [31:0] e_d0, logic [31:0] e_d1);
    vec_t v;
    v = '{c0, a0, c1, a1, d1, sa, sr, sd, e_cmd, e_addr, e_mdata, e_acc0, e_acc1, e_r0, e_r1, e_d0, e_d1};
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic drive(logic [2:0] c0, logic [31:0] a0, logic [2:0] c1, logic [31:0] a1,
      logic [31:0] d1, logic sa, logic [1:0] sr, logic [31:0] sd);
    m0_cmd = c0; m0_addr = a0; m1_cmd = c1; m1_addr = a1; m1_data = d1;
    s_acc = sa; s_resp = sr; s_data = sd;
  endtask

  task automatic chk_rr_idle(string tag);
    chk({tag, ".acc0"}, 32'(rr_acc0), 0);
    chk({tag, ".acc1"}, 32'(rr_acc1), 0);
    chk({tag, ".r0"}, 32'(rr_r0), 32'(N));
    chk({tag, ".r1"}, 32'(rr_r1), 32'(N));
    chk({tag, ".d0"}, rr_d0, 0);
    chk({tag, ".d1"}, rr_d1, 0);
    chk({tag, ".s_cmd"}, 32'(rr_s_cmd), 32'(I));
    chk({tag, ".s_addr"}, rr_s_addr, 0);
  endtask

  initial begin
    int n_rr, n_fp_m1;
    string t;
    tv[0]  = mk(I, 0, I, 0, 0, 0, N, 0, I, 0, 0, 0, 0, N, N, 0, 0);
    tv[1]  = mk(RD, 4, I, 0, 0, 1, N, 0, RD, 4, 0, 1, 0, N, N, 0, 0);
    tv[2]  = mk(I, 0, I, 0, 0, 0, D, 32'hDEADBEEF, I, 0, 0, 0, 0, D, N, 32'hDEADBEEF, 0);
    tv[3]  = mk(RD, 8, RD, 'hC, 0, 1, N, 0, RD, 'hC, 0, 0, 1, N, N, 0, 0);
    tv[4]  = mk(RD, 8, RD, 'hC, 0, 0, D, 32'h11111111, I, 0, 0, 0, 0, N, D, 0, 32'h11111111);
    tv[5]  = mk(RD, 8, RD, 'h10, 0, 1, N, 0, RD, 8, 0, 1, 0, N, N, 0, 0);
    tv[6]  = mk(RD, 8, RD, 'h10, 0, 0, D, 32'h22222222, I, 0, 0, 0, 0, D, N, 32'h22222222, 0);
    tv[7]  = mk(RD, 8, RD, 'h10, 0, 1, N, 0, RD, 'h10, 0, 0, 1, N, N, 0, 0);
    tv[8]  = mk(I, 0, I, 0, 0, 0, D, 32'h33333333, I, 0, 0, 0, 0, N, D, 0, 32'h33333333);
    tv[9]  = mk(I, 0, RD, 'h14, 0, 0, N, 0, RD, 'h14, 0, 0, 0, N, N, 0, 0);
    tv[10] = mk(I, 0, RD, 'h14, 0, 0, D, 32'h55555555, RD, 'h14, 0, 0, 0, N, N, 0, 0);
    tv[11] = mk(I, 0, RD, 'h14, 0, 0, N, 0, RD, 'h14, 0, 0, 0, N, N, 0, 0);
    tv[12] = mk(I, 0, RD, 'h14, 0, 1, N, 0, RD, 'h14, 0, 0, 1, N, N, 0, 0);
    tv[13] = mk(RD, 'h18, I, 0, 0, 1, N, 0, I, 0, 0, 0, 0, N, N, 0, 0);
    tv[14] = mk(RD, 'h18, I, 0, 0, 1, D, 32'h44444444, I, 0, 0, 0, 0, N, D, 0, 32'h44444444);
    tv[15] = mk(RD, 'h18, I, 0, 0, 1, N, 0, RD, 'h18, 0, 1, 0, N, N, 0, 0);
    tv[16] = mk(I, 0, I, 0, 0, 0, D, 32'h66666666, I, 0, 0, 0, 0, D, N, 32'h66666666, 0);
`ifdef ROM_ARB_WRITE_ERR_EN
    tv[17] = mk(I, 0, WR, 0, 'hABCD, 0, N, 0, I, 0, 0, 0, 1, N, N, 0, 0);
    tv[18] = mk(I, 0, I, 0, 0, 0, D, 32'h77777777, I, 0, 0, 0, 0, N, E, 0, 32'hFFFFFFFF);
`else
    tv[17] = mk(I, 0, WR, 0, 'hABCD, 1, N, 0, WR, 0, 'hABCD, 0, 1, N, N, 0, 0);
    tv[18] = mk(I, 0, I, 0, 0, 0, D, 32'h77777777, I, 0, 0, 0, 0, N, D, 0, 32'h77777777);
`endif
    tv[19] = mk(RD, 4, I, 0, 0, 1, N, 0, RD, 4, 0, 1, 0, N, N, 0, 0);
    tv[20] = mk(I, 0, I, 0, 0, 0, D, 32'hDEADBEEF, I, 0, 0, 0, 0, D, N, 32'hDEADBEEF, 0);

    m0_data = '0; m0_ben = 4'hF; m1_ben = 4'h3;
    drive(I, 0, I, 0, 0, 0, N, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_rr_idle("reset");
    @(posedge clk); #1 nrst = 1'b1;
    @(negedge clk);
    chk_rr_idle("post_reset");

    for (int i = 0; i < 21; i++) begin
      @(posedge clk); #1;
      drive(tv[i].c0, tv[i].a0, tv[i].c1, tv[i].a1, tv[i].d1, tv[i].sa, tv[i].sr, tv[i].sd);
      @(negedge clk);
      t = $sformatf("v%0d", i);
      chk({t, ".s_cmd"}, 32'(rr_s_cmd), 32'(tv[i].e_cmd));
      chk({t, ".s_addr"}, rr_s_addr, tv[i].e_addr);
      chk({t, ".s_mdata"}, rr_s_data, tv[i].e_mdata);
      chk({t, ".acc0"}, 32'(rr_acc0), 32'(tv[i].e_acc0));
      chk({t, ".acc1"}, 32'(rr_acc1), 32'(tv[i].e_acc1));
      chk({t, ".r0"}, 32'(rr_r0), 32'(tv[i].e_r0));
      chk({t, ".r1"}, 32'(rr_r1), 32'(tv[i].e_r1));
      chk({t, ".d0"}, rr_d0, tv[i].e_d0);
      chk({t, ".d1"}, rr_d1, tv[i].e_d1);
    end

    // Reset while a read is outstanding: the slave response must be discarded.
    @(posedge clk); #1 drive(RD, 4, I, 0, 0, 1, N, 0);
    @(negedge clk); chk("midrst.acc0", 32'(rr_acc0), 1);
    @(posedge clk); #1 drive(I, 0, I, 0, 0, 0, D, 32'h99);
    nrst = 1'b0;
    #1 chk("midrst.r0", 32'(rr_r0), 32'(N));
    chk("midrst.d0", rr_d0, 0);
    @(posedge clk); #1 nrst = 1'b1;
    @(negedge clk);
    chk("midrst.idle_r0", 32'(rr_r0), 32'(N));
    chk("midrst.idle_d0", rr_d0, 0);

    // Continuous contention from a fresh reset on both arbitration flavours.
    @(posedge clk); #1 nrst = 1'b0;
    drive(I, 0, I, 0, 0, 0, N, 0);
    @(posedge clk); #1 nrst = 1'b1;
    n_rr = 0; n_fp_m1 = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      drive(RD, 'h20, RD, 'h24, 0, k % 2 == 0, (k % 2 == 1) ? D : N, 32'(k + 'h100));
      @(negedge clk);
      t = $sformatf("cont%0d", k);
      if (rr_r0 == D || rr_r1 == D) n_rr++;
      if (fp_acc1) n_fp_m1++;
      if (k % 2 == 0) begin
        chk({t, ".rr_acc0"}, 32'(rr_acc0), 32'((k / 2) % 2 == 0));
        chk({t, ".rr_acc1"}, 32'(rr_acc1), 32'((k / 2) % 2 == 1));
        chk({t, ".rr_s_addr"}, rr_s_addr, ((k / 2) % 2 == 0) ? 32'h20 : 32'h24);
        chk({t, ".fp_acc0"}, 32'(fp_acc0), 1);
        chk({t, ".fp_s_addr"}, fp_s_addr, 32'h20);
      end else begin
        chk({t, ".rr_r0"}, 32'(rr_r0), ((k / 2) % 2 == 0) ? 32'(D) : 32'(N));
        chk({t, ".rr_r1"}, 32'(rr_r1), ((k / 2) % 2 == 1) ? 32'(D) : 32'(N));
        chk({t, ".rr_data"}, rr_d0 | rr_d1, 32'(k + 'h100));
        chk({t, ".fp_r0"}, 32'(fp_r0), 32'(D));
        chk({t, ".fp_r1"}, 32'(fp_r1), 32'(N));
      end
    end
    chk("cont.rr_responses", 32'(n_rr), 4);
    chk("cont.fp_m1_accepts", 32'(n_fp_m1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rom_arb.md
# rom_arb

Two-master OCP arbiter that shares one single-port OCP slave, normally `rom_top`, between two requesters such as instruction fetch and data load. It sits between the masters and the slave, with one transaction outstanding at a time. It routes the slave response back to the master that owns the transaction. Arbitration is round-robin by default, with a fixed-priority option.

## Interface
- FAIR, default 1: 1 selects round-robin; 0 selects fixed priority, where m0 always wins.
- clk  input  1  clock; all state updates on the rising edge.
- nrst  input  1  reset, asynchronous, active-low.
- i_m0_MAddr / i_m1_MAddr  input  `ADDR_WIDTH  master address.
- i_m0_MCmd / i_m1_MCmd  input  3  master command (`OCP_CMD_*`).
- i_m0_MData / i_m1_MData  input  `DATA_WIDTH  master write data.
- i_m0_MByteEn / i_m1_MByteEn  input  `BEN_WIDTH  master byte enables.
- o_m0_SCmdAccept / o_m1_SCmdAccept  output  1  command accepted this cycle.
- o_m0_SData / o_m1_SData  output  `DATA_WIDTH  read data, valid with DVA.
- o_m0_SResp / o_m1_SResp  output  2  response (`OCP_RESP_*`).
- o_s_MAddr, o_s_MCmd, o_s_MData, o_s_MByteEn  output  same widths as master side  forwarded command to the slave.
- i_s_SCmdAccept  input  1  slave accepts the command.
- i_s_SData  input  `DATA_WIDTH  slave read data.
- i_s_SResp  input  2  slave response.

## Operation
- FSM states: IDLE and WAIT. Registered state: state, owner (1 bit), prio (1 bit, the master favoured on the next tie), and, when configured, err_pend.
- IDLE, no request (both MCmd == `OCP_CMD_IDLE`):
  - o_s_MCmd = IDLE; other slave outputs are don't-care, driven 0.
  - Both accepts are 0.
- IDLE, one requester: that master is granted.
- IDLE, both requesting:
  - FAIR=1: the grant goes to prio.
  - FAIR=0: the grant goes to m0.
- On grant, the selected master's MAddr/MCmd/MData/MByteEn drive the slave combinationally.
- o_mX_SCmdAccept = granted & i_s_SCmdAccept; the non-granted master sees 0.
- Accept handshake (i_s_SCmdAccept=1 with a non-IDLE command):
  - owner <= granted master; state <= WAIT.
  - If FAIR=1, prio <= ~granted.
- If the slave does not accept, nothing is latched. Arbitration re-evaluates next cycle, and the grant may change.
- WAIT:
  - o_s_MCmd = IDLE; both accepts are 0.
  - o_owner_SResp = i_s_SResp and o_owner_SData = i_s_SData, passed through combinationally.
  - The non-owner sees SResp = `OCP_RESP_NULL` and SData = 0.
- Leaving WAIT: when i_s_SResp != `OCP_RESP_NULL`, state <= IDLE. The next command can be accepted the following cycle.
- A slave response arriving in IDLE is a protocol error. It is dropped and not routed to either master.

## Timing
- Reset values:
  - state=IDLE, owner=0, prio=0, err_pend=0.
  - All o_m*_SResp = NULL, all o_m*_SData = 0, all o_m*_SCmdAccept = 0.
  - o_s_MCmd = IDLE, other o_s_* = 0.
- Command path is zero-latency: master to slave and slave accept to master both pass combinationally.
- Response path adds no cycles. With `rom_top`, accept at cycle N gives DVA at N+1.
- Throughput is one transaction per 2 cycles per slave.
- Reset mid-transaction returns to IDLE immediately. A pending slave response is discarded.
- A master must hold its command stable until accepted, per OCP.

## Configuration
- ROM_ARB_WRITE_ERR_EN defined: an `OCP_CMD_WRITE` that wins arbitration is not forwarded.
  - o_s_MCmd stays IDLE.
  - The write is accepted locally: SCmdAccept=1 regardless of i_s_SCmdAccept.
  - err_pend <= 1 and state <= WAIT.
  - Next cycle the owner gets `OCP_RESP_ERR` with SData = all ones; i_s_SResp is ignored; the block returns to IDLE.
  - Round-robin prio updates as for a normal grant.
- ROM_ARB_WRITE_ERR_EN undefined: writes are forwarded to the slave like reads. There is no err_pend logic.

## Test plan
- Reset: with nrst low, all outputs hold reset values. After release, with no requests, o_s_MCmd=IDLE and both SResp=NULL.
- Single read: m0 reads 0x4 from ROM holding 0xDEADBEEF at word 1.
  - Cycle N: o_m0_SCmdAccept=1.
  - Cycle N+1: o_m0_SResp=DVA and o_m0_SData=0xDEADBEEF; m1 sees NULL.
- Contention, FAIR=1: both masters hold reads for 8 cycles. Grants alternate m0, m1, m0, m1, each response goes only to its owner, and there are 4 responses total.
- Contention, FAIR=0: both masters request continuously; m0 wins every arbitration and m1 is never accepted.
- Slave backpressure: i_s_SCmdAccept held 0 for 3 cycles.
  - No master is accepted and the state stays IDLE.
  - On cycle 4, accept and DVA arrive one cycle later.
- Write with ROM_ARB_WRITE_ERR_EN: m1 writes 0x0.
  - Slave MCmd stays IDLE and o_m1_SCmdAccept=1.
  - Next cycle o_m1_SResp=ERR and SData=0xFFFFFFFF.
  - Without the macro, the slave sees WRITE and m1 gets DVA.
